// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue
//   Sequential instruction fetch unit: PC generator, valid/ready request
//   port to instruction memory, and an instruction FIFO feeding decode.
//   A redirect from execute flushes the FIFO, marks all in-flight
//   responses for dropping and restarts fetch at the target.
//
// Ports
//   clk_in, reset_in            clock, synchronous active-high reset
//   redirect_valid_in/addr_in   one-cycle redirect strobe and target
//   imem_req_valid_o/addr_o     fetch request (word aligned)
//   imem_req_ready_in           memory accepts request
//   imem_rsp_valid_in/data_in   in-order response, always accepted
//   inst_valid_o/data_o/pc_o    FIFO head to decode
//   inst_ready_in               decode consumes head
module rv32i_fetch_queue #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_addr_in,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_in,
  input  logic            imem_rsp_valid_in,
  input  logic [31:0]     imem_rsp_data_in,
  output logic            inst_valid_o,
  output logic [31:0]     inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_in
);

  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP_C  = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_q [FIFO_DEPTH];

  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  always_comb begin
    target = redirect_addr_in & ~XLEN'(3);
  end

  // Credits come only from registered counters, so a slot freed by a pop
  // or response this cycle is not reused until the next one.
  always_comb begin
    imem_req_valid_o = !reset_in && !redirect_valid_in && ((outst_q + count_q) < DEPTH_C);
    imem_req_addr_o  = reset_in ? RESET_VECTOR : fetch_pc_q;
    inst_valid_o     = !reset_in && (count_q != '0);
    inst_data_o      = fifo_q[rd_ptr_q];
    inst_pc_o        = reset_in ? RESET_VECTOR : deliver_pc_q;
  end

  always_comb begin
    req_fire = imem_req_valid_o && imem_req_ready_in;
    rsp_take = imem_rsp_valid_in && (outst_q != '0);
    pop      = inst_valid_o && inst_ready_in && !redirect_valid_in;
    push     = rsp_take && (drop_q == '0) && !redirect_valid_in;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    drop_d       = drop_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    outst_d      = outst_q + CW'(req_fire) - CW'(rsp_take);

    if (redirect_valid_in) begin
      // Everything still in flight after this cycle belongs to the old
      // stream and must be discarded on arrival.
      fetch_pc_d   = target;
      deliver_pc_d = target;
      count_d      = '0;
      rd_ptr_d     = wr_ptr_q;
      drop_d       = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP_C;
      if (pop) begin
        deliver_pc_d = deliver_pc_q + STEP_C;
        rd_ptr_d     = rd_ptr_q + AW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      fetch_pc_q   <= RESET_VECTOR;
      deliver_pc_q <= RESET_VECTOR;
      outst_q      <= '0;
      drop_q       <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !reset_in) fifo_q[wr_ptr_q] <= imem_rsp_data_in;
  end

endmodule
